// File: rtl/cmp_arbiter_if.sv
`default_nettype none
// ============================================================================
//  cmp_arbiter_if
//  Request/response bundle for the shared comparator arbiter.
//  Revision: 1.0
// ============================================================================
interface cmp_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 3
);
    logic             flush;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_signed;
    logic [CW-1:0]    req0_cond;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_signed;
    logic [CW-1:0]    req1_cond;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_result;
    logic [15:0]      grant_cnt0;
    logic [15:0]      grant_cnt1;

    modport slave (
        input  flush,
        input  req0_valid, req0_a, req0_b, req0_signed, req0_cond,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_signed, req1_cond,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        input  rsp_ready,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output flush,
        output req0_valid, req0_a, req0_b, req0_signed, req0_cond,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_signed, req1_cond,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        output rsp_ready,
        input  grant_cnt0, grant_cnt1
    );
endinterface
`default_nettype wire

// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  cmp_arbiter
//  Round-robin sharing of one 32-bit comparator between two requesters.
//  Revision: 1.0
// ============================================================================
module cmp_arbiter #(
    parameter int WIDTH = 32,
    parameter int CW    = 3
) (
    input  wire logic      clk,
    input  wire logic      reset,
    cmp_arbiter_if.slave   bus
);
    localparam logic [CW-1:0] c_COND_EQ = CW'(0);
    localparam logic [CW-1:0] c_COND_NE = CW'(1);
    localparam logic [CW-1:0] c_COND_LT = CW'(2);
    localparam logic [CW-1:0] c_COND_LE = CW'(3);
    localparam logic [CW-1:0] c_COND_GT = CW'(4);
    localparam logic [CW-1:0] c_COND_GE = CW'(5);
    localparam logic [CW-1:0] c_COND_AT = CW'(6);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic             r_rr_ptr;
    logic             r_rsp_id;
    logic             r_rsp_result;
    logic [15:0]      r_cnt0;
    logic [15:0]      r_cnt1;

    logic             w_slot_free;
    logic             w_grant_en;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any_gnt;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_signed;
    logic [CW-1:0]    w_sel_cond;
    logic [WIDTH-1:0] w_key_a;
    logic [WIDTH-1:0] w_key_b;
    logic             w_eq;
    logic             w_lt;
    logic             w_result;

    assign w_slot_free = (r_state == S_EMPTY) | bus.rsp_ready;
    assign w_grant_en  = w_slot_free & ~bus.flush & ~reset;
    assign w_gnt0      = w_grant_en & bus.req0_valid & (~bus.req1_valid | ~r_rr_ptr);
    assign w_gnt1      = w_grant_en & bus.req1_valid & (~bus.req0_valid |  r_rr_ptr);
    assign w_any_gnt   = w_gnt0 | w_gnt1;

    assign w_sel_a      = w_gnt1 ? bus.req1_a      : bus.req0_a;
    assign w_sel_b      = w_gnt1 ? bus.req1_b      : bus.req0_b;
    assign w_sel_signed = w_gnt1 ? bus.req1_signed : bus.req0_signed;
    assign w_sel_cond   = w_gnt1 ? bus.req1_cond   : bus.req0_cond;

    // Flipping the sign bit maps signed ordering onto the unsigned comparator.
    assign w_key_a = {w_sel_a[WIDTH-1] ^ w_sel_signed, w_sel_a[WIDTH-2:0]};
    assign w_key_b = {w_sel_b[WIDTH-1] ^ w_sel_signed, w_sel_b[WIDTH-2:0]};
    assign w_eq    = (w_sel_a == w_sel_b);
    assign w_lt    = (w_key_a < w_key_b);

    always_comb begin
        w_result = 1'b0;
        case (w_sel_cond)
            c_COND_EQ: w_result = w_eq;
            c_COND_NE: w_result = ~w_eq;
            c_COND_LT: w_result = w_lt;
            c_COND_LE: w_result = w_lt | w_eq;
            c_COND_GT: w_result = ~w_lt & ~w_eq;
            c_COND_GE: w_result = ~w_lt;
            c_COND_AT: w_result = 1'b1;
            default:   w_result = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
        end else if (w_any_gnt) begin
            w_state_nxt = S_FULL;
        end else if (r_state == S_FULL && bus.rsp_ready) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_EMPTY;
            r_rr_ptr     <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 1'b0;
            r_cnt0       <= 16'd0;
            r_cnt1       <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_any_gnt) begin
                r_rsp_id     <= w_gnt1;
                r_rsp_result <= w_result;
                r_rr_ptr     <= w_gnt0;
            end
            if (w_gnt0) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_gnt1) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.rsp_valid  = (r_state == S_FULL);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.grant_cnt0 = r_cnt0;
    assign bus.grant_cnt1 = r_cnt1;
endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_cmp_arbiter
//  Directed and randomized checks of cmp_arbiter against a behavioural model.
//  Revision: 1.0
// ============================================================================
module tb_cmp_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cmp_arbiter_if #(.WIDTH(32), .CW(3)) bus ();

    cmp_arbiter #(.WIDTH(32), .CW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural model state
    bit        m_init  = 1'b0;
    bit        m_valid = 1'b0;
    bit        m_id    = 1'b0;
    bit        m_res   = 1'b0;
    bit        m_rr    = 1'b0;
    bit [15:0] m_cnt0  = 16'd0;
    bit [15:0] m_cnt1  = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_eval(input logic [31:0] a, input logic [31:0] b,
                                    input logic s, input logic [2:0] c);
        longint va, vb;
        va = s ? longint'($signed(a)) : longint'(a);
        vb = s ? longint'($signed(b)) : longint'(b);
        case (c)
            3'd0:    return va == vb;
            3'd1:    return va != vb;
            3'd2:    return va <  vb;
            3'd3:    return va <= vb;
            3'd4:    return va >  vb;
            3'd5:    return va >= vb;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns one-hot {port1, port0} grant for the current cycle.
    function automatic bit [1:0] model_grant();
        bit may;
        may = (!m_valid || bus.rsp_ready) && !bus.flush && !reset;
        if (!may) return 2'b00;
        if (bus.req0_valid && bus.req1_valid) return m_rr ? 2'b10 : 2'b01;
        if (bus.req0_valid) return 2'b01;
        if (bus.req1_valid) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        bit [1:0] g;
        g = model_grant();
        if (reset) begin
            m_init  <= 1'b1;
            m_valid <= 1'b0;
            m_id    <= 1'b0;
            m_res   <= 1'b0;
            m_rr    <= 1'b0;
            m_cnt0  <= 16'd0;
            m_cnt1  <= 16'd0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (g == 2'b01) begin
            m_valid <= 1'b1;
            m_id    <= 1'b0;
            m_res   <= ref_eval(bus.req0_a, bus.req0_b, bus.req0_signed, bus.req0_cond);
            m_rr    <= 1'b1;
            m_cnt0  <= m_cnt0 + 16'd1;
        end else if (g == 2'b10) begin
            m_valid <= 1'b1;
            m_id    <= 1'b1;
            m_res   <= ref_eval(bus.req1_a, bus.req1_b, bus.req1_signed, bus.req1_cond);
            m_rr    <= 1'b0;
            m_cnt1  <= m_cnt1 + 16'd1;
        end else if (bus.rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        bit [1:0] g;
        if (m_init) begin
            g = model_grant();
            chk("req0_ready", 32'(bus.req0_ready), 32'(g[0]));
            chk("req1_ready", 32'(bus.req1_ready), 32'(g[1]));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
                chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
            end
            chk("grant_cnt0", 32'(bus.grant_cnt0), 32'(m_cnt0));
            chk("grant_cnt1", 32'(bus.grant_cnt1), 32'(m_cnt1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_b(input logic [31:0] a);
        case ($urandom_range(3))
            0:       return a;
            1:       return a + 32'd1;
            2:       return a ^ 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_port0();
        bus.req0_valid  = ($urandom_range(2) != 0);
        bus.req0_a      = $urandom;
        bus.req0_b      = rand_b(bus.req0_a);
        bus.req0_signed = $urandom_range(1) != 0;
        bus.req0_cond   = 3'($urandom_range(7));
    endtask

    task automatic rand_port1();
        bus.req1_valid  = ($urandom_range(2) != 0);
        bus.req1_a      = $urandom;
        bus.req1_b      = rand_b(bus.req1_a);
        bus.req1_signed = $urandom_range(1) != 0;
        bus.req1_cond   = 3'($urandom_range(7));
    endtask

    initial begin
        bit rdy0, rdy1;
        reset           = 1'b1;
        bus.flush       = 1'b0;
        bus.rsp_ready   = 1'b1;
        bus.req0_valid  = 1'b1;
        bus.req0_a      = 32'd0;
        bus.req0_b      = 32'd0;
        bus.req0_signed = 1'b0;
        bus.req0_cond   = 3'd0;
        bus.req1_valid  = 1'b1;
        bus.req1_a      = 32'd0;
        bus.req1_b      = 32'd0;
        bus.req1_signed = 1'b0;
        bus.req1_cond   = 3'd0;

        // Reset held for two edges with requests present
        cyc();
        @(negedge clk);
        chk("lit_rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("lit_rst_ready1", 32'(bus.req1_ready), 32'd0);
        chk("lit_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("lit_rst_cnt0", 32'(bus.grant_cnt0), 32'd0);
        cyc();
        reset = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("lit_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("lit_idle_cnt1", 32'(bus.grant_cnt1), 32'd0);

        // Signed then unsigned less-than on the same operands
        bus.req0_valid = 1'b1; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1;
        bus.req0_signed = 1'b1; bus.req0_cond = 3'd2;
        @(negedge clk);
        chk("lit_slt_ready0", 32'(bus.req0_ready), 32'd1);
        cyc();
        bus.req0_signed = 1'b0;
        @(negedge clk);
        chk("lit_slt_valid", 32'(bus.rsp_valid), 32'd1);
        chk("lit_slt_id", 32'(bus.rsp_id), 32'd0);
        chk("lit_slt_result", 32'(bus.rsp_result), 32'd1);
        cyc();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("lit_ult_result", 32'(bus.rsp_result), 32'd0);

        // Contention from a fresh round-robin pointer
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd5;
        bus.req0_signed = 1'b0; bus.req0_cond = 3'd0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd7; bus.req1_b = 32'd3;
        bus.req1_signed = 1'b0; bus.req1_cond = 3'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lit_rr_ready0", 32'(bus.req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                chk("lit_rr_id", 32'(bus.rsp_id), ((i - 1) % 2 == 0) ? 32'd0 : 32'd1);
                chk("lit_rr_result", 32'(bus.rsp_result), 32'd1);
            end
            cyc();
        end

        // Backpressure: slot holds id 1 while port 0 waits
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("lit_rr_cnt0", 32'(bus.grant_cnt0), 32'd2);
        chk("lit_rr_cnt1", 32'(bus.grant_cnt1), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("lit_bp_id", 32'(bus.rsp_id), 32'd1);
            chk("lit_bp_result", 32'(bus.rsp_result), 32'd1);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("lit_bp_release_ready0", 32'(bus.req0_ready), 32'd1);
        cyc();
        bus.req0_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("lit_bp_new_id", 32'(bus.rsp_id), 32'd0);

        // Flush with the slot full
        bus.flush = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("lit_flush_ready1", 32'(bus.req1_ready), 32'd0);
        cyc();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("lit_flush_valid", 32'(bus.rsp_valid), 32'd0);
        chk("lit_flush_after_ready1", 32'(bus.req1_ready), 32'd1);
        cyc();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("lit_flush_after_id", 32'(bus.rsp_id), 32'd1);

        // Randomized traffic; held requests stay stable until accepted or dropped
        rand_port0();
        rand_port1();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rdy0 = bus.req0_ready;
            rdy1 = bus.req1_ready;
            cyc();
            if (!(bus.req0_valid && !rdy0 && $urandom_range(9) != 0)) rand_port0();
            if (!(bus.req1_valid && !rdy1 && $urandom_range(9) != 0)) rand_port1();
            bus.rsp_ready = ($urandom_range(3) != 0);
            bus.flush     = ($urandom_range(19) == 0);
            reset         = ($urandom_range(199) == 0);
        end

        // Counter wrap on port 1 using the reserved condition
        bus.req0_valid = 1'b0;
        bus.flush = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.req1_signed = 1'b0; bus.req1_cond = 3'd7;
        for (int i = 0; i < 65536; i++) begin
            cyc();
            if (i == 0) begin
                @(negedge clk);
                chk("lit_cond7_result", 32'(bus.rsp_result), 32'd0);
            end
        end
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("lit_wrap_cnt1", 32'(bus.grant_cnt1), 32'd0);
        bus.req1_valid = 1'b1;
        bus.req1_cond = 3'd6;
        cyc();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("lit_cond6_result", 32'(bus.rsp_result), 32'd1);
        chk("lit_cond6_cnt1", 32'(bus.grant_cnt1), 32'd1);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares a single 32-bit magnitude/equality comparator between two requesters: port 0 is the ID-stage branch resolver, port 1 is the EX-stage set-less-than path.
- Each requester issues an operand pair plus a condition code over a valid/ready handshake.
- The block arbitrates round-robin, evaluates the condition and returns a 1-bit result through a single registered response slot tagged with the requester id.
- A flush input discards in-flight work on pipeline redirect.

Parameters:
WIDTH, 32, operand width in bits
CW, 3, condition-code width

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline flush; drops the held response and blocks grants this cycle
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_a  in  WIDTH  port 0 operand A
req0_b  in  WIDTH  port 0 operand B
req0_signed  in  1  port 0: 1 = signed compare, 0 = unsigned
req0_cond  in  CW  port 0 condition code
req1_valid, req1_ready, req1_a, req1_b, req1_signed, req1_cond  same as port 0, for port 1
rsp_valid  out  1  response slot holds a result
rsp_ready  in  1  consumer takes the response this cycle
rsp_id  out  1  requester that owns the response (0 or 1)
rsp_result  out  1  evaluated condition
grant_cnt0  out  16  number of port 0 grants since reset, wraps
grant_cnt1  out  16  number of port 1 grants since reset, wraps

Behaviour:
- Reset (sync, high): rsp_valid=0, rsp_id=0, rsp_result=0, rr_ptr=0 (port 0 preferred), grant_cnt0=grant_cnt1=0. A pending response is discarded. reqN_ready is 0 while reset is high.
- Condition codes:
  - 0 = eq, 1 = ne, 2 = lt, 3 = le, 4 = gt, 5 = ge, 6 = always true, 7 = reserved (result 0).
  - lt/gt use signed or unsigned ordering per reqN_signed.
  - eq/ne ignore reqN_signed.
  - le = lt|eq, ge = gt|eq.
- Slot free: slot_free = !rsp_valid | rsp_ready.
- Grant rule, combinational: when slot_free & !flush & !reset:
  - Only one port valid: that port is granted.
  - Both valid: port rr_ptr is granted.
  - reqN_ready = grantN. At most one ready per cycle.
- Round-robin: on any grant to port N, rr_ptr <= ~N on the next edge. With no grant, rr_ptr holds.
- Handshake:
  - A request transfers when valid & ready.
  - The requester holds a/b/signed/cond stable while valid & !ready.
  - valid may drop without transfer; no state is kept for a dropped request.
- Latency and state machine:
  - The comparator evaluates the granted operands combinationally. The result is registered in the slot: grant at edge N gives rsp_valid=1 after edge N.
  - Slot states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY→FULL on grant.
  - FULL→FULL on grant & rsp_ready (back-to-back, throughput 1 per cycle); the slot is overwritten with the new id/result.
  - FULL→EMPTY on rsp_ready & no grant.
  - FULL holds on !rsp_ready: id and result stable, no grant.
- Flush: next edge rsp_valid=0 regardless of rsp_ready; no grant that cycle. rsp_id/rsp_result keep their old values but are don't-care. rr_ptr and counters are unchanged. flush and reset together behave as reset.
- Counters: grant_cntN increments on each grant to port N; 16'hFFFF wraps to 0.
- Outputs rsp_* and grant_cnt* come directly from registers (no combinational path from inputs).

Test Plan:
- Reset then idle: reset=1 for 2 cycles → rsp_valid=0, req0_ready=req1_ready=0 during reset, counters 0; after release with no requests everything stays 0.
- Single signed lt: req0 a=32'hFFFF_FFFF, b=1, signed=1, cond=2 → req0_ready=1 same cycle, next cycle rsp_valid=1, rsp_id=0, rsp_result=1. Same operands with signed=0 → result 0.
- Contention round-robin: both ports valid for 4 cycles, rsp_ready=1, port0 cond=0 (a=b=5), port1 cond=4 (a=7, b=3) → grants alternate 0,1,0,1. Responses: id 0/1/0/1, result 1 each. grant_cnt0=2, grant_cnt1=2.
- Backpressure: rsp_ready=0 with slot FULL (id 1, result 1) and req0 valid → req0_ready=0 and the response holds for 3 cycles. Raising rsp_ready grants req0 that cycle; the next cycle shows id 0.
- Flush: slot FULL, flush=1 with req1 valid → req1_ready=0, next cycle rsp_valid=0. Next cycle req1 is granted normally.
- Wrap and reserved: 65536 port-1 grants → grant_cnt1 returns to 0. cond=7 → rsp_result=0. cond=6 → rsp_result=1.
